serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
Bit-serial multi-bit adder that wraps a single one-bit full adder cell. The block latches two WIDTH-bit operands and a carry-in on a START request. It then presents one bit pair per clock, LSB first, to the full adder, keeping the carry in a register between cycles. It assembles the sum bits into a result register and signals completion with a one-cycle DONE pulse; it sits between operand-producing logic and the one-bit adder cell.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range 1..32

Ports:
CLK  input  1  clock; all state updates on rising edge
RST_N  input  1  synchronous active-low reset, sampled on rising edge of CLK
START  input  1  request; sampled only in IDLE or DONE_ST
A  input  WIDTH  operand A; captured when START is accepted
B  input  WIDTH  operand B; captured when START is accepted
C_I  input  1  carry-in; captured when START is accepted
BUSY  output  1  high while an addition is in progress (state RUN)
DONE  output  1  one-cycle completion pulse (state DONE_ST)
S  output  WIDTH  registered sum; holds last completed result
C_O  output  1  registered carry-out; holds last completed result

Behaviour:
- Reset: RST_N low at a rising edge forces the following; any operation in flight is abandoned, with no DONE pulse.
  - state IDLE
  - BUSY=0, DONE=0, S=0, C_O=0
  - internal operand/sum shift registers, carry register and bit counter = 0
- States: IDLE, RUN, DONE_ST. BUSY = (state==RUN); DONE = (state==DONE_ST); both are decoded from registered state only.
- IDLE: START=1 at an edge accepts the request:
  - a_sr<=A, b_sr<=B, carry<=C_I, cnt<=0, state<=RUN
  - START=0 leaves the state in IDLE.
- RUN, each edge:
  - the full adder inputs are a_sr[0], b_sr[0], carry
  - sum_sr<={fa_S, sum_sr[WIDTH-1:1]}, i.e. the sum bit enters at the MSB and the register shifts right
  - a_sr and b_sr shift right by 1
  - carry<=fa_C_O, cnt<=cnt+1
  - On the edge where cnt==WIDTH-1: S<={fa_S, sum_sr[WIDTH-1:1]}, C_O<=fa_C_O, state<=DONE_ST.
- DONE_ST lasts exactly one cycle. The next edge goes to RUN if START=1 (accepted exactly as in IDLE, allowing back-to-back operations), otherwise to IDLE.
- Latency: START accepted at edge t0 → BUSY high after t0 through edge t(WIDTH) → DONE high for the single cycle after edge t(WIDTH). S/C_O update at that same edge.
- START while in RUN is ignored and has no effect on the operation in progress. A/B/C_I changes after acceptance are ignored.
- S/C_O change only at operation completion or reset. They hold their value through IDLE and through a subsequent RUN until that RUN completes.
- Arithmetic: {C_O,S} = A + B + C_I, computed modulo 2^(WIDTH+1); no overflow flag.
- cnt width: $clog2(WIDTH)+1 bits; it never wraps within an operation.
- WIDTH=1: RUN lasts one cycle; DONE high on the cycle after the edge following acceptance.

Test Plan:
1. Hold RST_N=0 for 2 edges with random inputs → BUSY=0, DONE=0, S=0x00, C_O=0.
2. WIDTH=8, A=0x5A, B=0x3C, C_I=0, START pulsed one cycle → BUSY high for 8 cycles; DONE high on the 8th edge after acceptance for one cycle; S=0x96, C_O=0, held afterwards.
3. Carry propagation:
   - A=0xFF, B=0x01, C_I=0 → S=0x00, C_O=1
   - A=0xFF, B=0xFF, C_I=1 → S=0xFF, C_O=1
4. START held high continuously with A=0x01, B=0x02 → operations repeat back-to-back: DONE every 9 cycles, BUSY low only during DONE cycles, S=0x03 each time. A START pulse and operand change mid-RUN → no restart; result still matches the originally captured operands.
5. Reset mid-operation: A=0x80, B=0x80, START, RST_N=0 at 4th RUN edge → next cycle BUSY=0, S=0x00, C_O=0, and no DONE pulse. A new START then yields S=0x00, C_O=1.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full adder cell is reused LSB-first over WIDTH cycles,
// with the carry held in a register between cycles.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_i,
    output logic s,
    output logic c_o
);
    assign s   = a ^ b ^ c_i;
    assign c_o = (a & b) | (c_i & (a ^ b));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C_I,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] S,
    output logic             C_O,
    output logic [1:0]       state_dbg
);
    // Handshake: START is a level request sampled only in IDLE or DONE_ST; a high
    // START at such an edge is accepted, operands are captured and BUSY rises.
    // DONE is a single-cycle pulse; S/C_O are valid from that cycle until the next
    // completion or reset.

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RUN     = 2'd1;
    localparam logic [1:0] DONE_ST = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic [WIDTH-1:0] sum_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_c_o;
    logic             last_bit;

    full_adder u_fa (
        .a   (a_sr[0]),
        .b   (b_sr[0]),
        .c_i (carry),
        .s   (fa_s),
        .c_o (fa_c_o)
    );

    // The new sum bit enters at the MSB so after WIDTH shifts bit 0 holds the LSB.
    generate
        if (WIDTH == 1) begin : g_w1
            assign sum_next = fa_s;
        end else begin : g_wn
            assign sum_next = {fa_s, sum_sr[WIDTH-1:1]};
        end
    endgenerate

    assign last_bit  = (cnt == CW'(WIDTH - 1));
    assign BUSY      = (state == RUN);
    assign DONE      = (state == DONE_ST);
    assign state_dbg = state;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            S      <= '0;
            C_O    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE_ST: begin
                    if (START) begin
                        a_sr  <= A;
                        b_sr  <= B;
                        carry <= C_I;
                        cnt   <= '0;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    sum_sr <= sum_next;
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    carry  <= fa_c_o;
                    cnt    <= cnt + 1'b1;
                    if (last_bit) begin
                        S     <= sum_next;
                        C_O   <= fa_c_o;
                        state <= DONE_ST;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: a queue-based reference model checked every cycle,
// plus literal expectations for the hand-computed vectors.

module tb_serial_adder;
    localparam int WIDTH = 8;

    logic             CLK = 1'b0;
    logic             RST_N = 1'b0;
    logic             START = 1'b0;
    logic [WIDTH-1:0] A = '0;
    logic [WIDTH-1:0] B = '0;
    logic             C_I = 1'b0;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] S;
    logic             C_O;
    logic [1:0]       state_dbg;

    int n_vec  = 0;
    int n_fail = 0;
    bit check_en = 1'b0;

    // reference model state
    logic [WIDTH:0]   exp_q[$];
    bit               m_busy = 1'b0;
    bit               m_done = 1'b0;
    int               rem = 0;
    logic [WIDTH-1:0] exp_s = '0;
    logic             exp_co = 1'b0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .START     (START),
        .A         (A),
        .B         (B),
        .C_I       (C_I),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .S         (S),
        .C_O       (C_O),
        .state_dbg (state_dbg)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: an accepted request completes WIDTH edges later with A+B+C_I.
    always @(posedge CLK) begin
        if (!RST_N) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            rem    = 0;
            exp_s  = '0;
            exp_co = 1'b0;
            exp_q.delete();
        end else if (m_busy) begin
            rem--;
            if (rem == 0) begin
                m_busy = 1'b0;
                m_done = 1'b1;
                {exp_co, exp_s} = exp_q.pop_front();
            end
        end else begin
            m_done = 1'b0;
            if (START) begin
                exp_q.push_back({1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, C_I});
                m_busy = 1'b1;
                rem    = WIDTH;
            end
        end
    end

    always @(negedge CLK) begin
        if (check_en) begin
            chk("busy", 32'(BUSY), 32'(m_busy));
            chk("done", 32'(DONE), 32'(m_done));
            chk("s",    32'(S),    32'(exp_s));
            chk("c_o",  32'(C_O),  32'(exp_co));
            chk("state_legal", 32'(state_dbg == 2'b11), 32'd0);
        end
    end

    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic ci);
        @(negedge CLK);
        A = a; B = b; C_I = ci; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    // Waits at negedges for DONE; returns the number of BUSY cycles observed before it.
    task automatic wait_done(output int busy_cycles);
        int guard;
        busy_cycles = 0;
        guard = 0;
        while (DONE !== 1'b1 && guard < 64) begin
            if (BUSY === 1'b1) busy_cycles++;
            @(negedge CLK);
            guard++;
        end
        chk("done_timeout", 32'(guard >= 64), 32'd0);
    endtask

    initial begin
        int bc;
        int gap;
        bit seen;

        // 1: reset with random inputs
        RST_N = 1'b0;
        repeat (2) begin
            @(negedge CLK);
            A = WIDTH'($urandom); B = WIDTH'($urandom);
            C_I = 1'($urandom_range(0, 1)); START = 1'($urandom_range(0, 1));
        end
        @(negedge CLK);
        check_en = 1'b1;
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_s",    32'(S),    32'h00);
        chk("rst_c_o",  32'(C_O),  32'd0);
        START = 1'b0;
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);

        // 2: basic add and latency
        start_op(8'h5A, 8'h3C, 1'b0);
        wait_done(bc);
        chk("t2_busy_cycles", 32'(bc), 32'd8);
        @(negedge CLK);
        chk("t2_s", 32'(S), 32'h96);
        chk("t2_c_o", 32'(C_O), 32'd0);
        repeat (3) @(negedge CLK);
        chk("t2_s_hold", 32'(S), 32'h96);

        // 3: carry propagation
        start_op(8'hFF, 8'h01, 1'b0);
        wait_done(bc);
        chk("t3a_s", 32'(S), 32'h00);
        chk("t3a_c_o", 32'(C_O), 32'd1);
        start_op(8'hFF, 8'hFF, 1'b1);
        wait_done(bc);
        chk("t3b_s", 32'(S), 32'hFF);
        chk("t3b_c_o", 32'(C_O), 32'd1);
        repeat (2) @(negedge CLK);

        // 4a: START held high, back-to-back operations
        A = 8'h01; B = 8'h02; C_I = 1'b0; START = 1'b1;
        @(negedge CLK);
        wait_done(bc);
        for (int i = 0; i < 3; i++) begin
            gap = 0;
            @(negedge CLK);
            gap++;
            while (DONE !== 1'b1 && gap < 40) begin
                @(negedge CLK);
                gap++;
            end
            chk("t4_done_period", 32'(gap), 32'd9);
            chk("t4_s", 32'(S), 32'h03);
        end
        START = 1'b0;
        repeat (2) @(negedge CLK);

        // 4b: START pulse and operand change mid-RUN are ignored
        start_op(8'h10, 8'h20, 1'b0);
        repeat (2) @(negedge CLK);
        A = 8'hFF; B = 8'hFF; C_I = 1'b1; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        wait_done(bc);
        chk("t4b_busy_cycles", 32'(bc), 32'd5);
        chk("t4b_s", 32'(S), 32'h30);
        chk("t4b_c_o", 32'(C_O), 32'd0);
        repeat (2) @(negedge CLK);

        // 5: reset on the 4th RUN edge abandons the operation
        start_op(8'h80, 8'h80, 1'b0);
        repeat (3) @(negedge CLK);
        RST_N = 1'b0;
        @(negedge CLK);
        chk("t5_busy", 32'(BUSY), 32'd0);
        chk("t5_s", 32'(S), 32'h00);
        chk("t5_c_o", 32'(C_O), 32'd0);
        RST_N = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge CLK);
            if (DONE === 1'b1) seen = 1'b1;
        end
        chk("t5_no_done", 32'(seen), 32'd0);
        start_op(8'h80, 8'h80, 1'b0);
        wait_done(bc);
        chk("t5_s_new", 32'(S), 32'h00);
        chk("t5_c_o_new", 32'(C_O), 32'd1);
        repeat (3) @(negedge CLK);

        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
